// File: rtl/icache_if.sv
// Bundle of the IFU-facing and mem_ctrler-facing signals of the instruction cache.
// slave: the cache itself. master: the environment (IFU plus mem_ctrler).
interface icache_if;
    logic [31:0] addr_from_ifu;
    logic        valid_from_ifu;
    logic        cancel_from_ifu;
    logic [31:0] inst_to_ifu;
    logic        ready_to_ifu;
    logic [31:0] addr_to_mem_ctrler;
    logic        valid_to_mem_ctrler;
    logic [31:0] data_from_mem_ctrler;
    logic        ready_from_mem_ctrler;

    modport slave (
        input  addr_from_ifu, valid_from_ifu, cancel_from_ifu,
        input  data_from_mem_ctrler, ready_from_mem_ctrler,
        output inst_to_ifu, ready_to_ifu, addr_to_mem_ctrler, valid_to_mem_ctrler
    );

    modport master (
        output addr_from_ifu, valid_from_ifu, cancel_from_ifu,
        output data_from_mem_ctrler, ready_from_mem_ctrler,
        input  inst_to_ifu, ready_to_ifu, addr_to_mem_ctrler, valid_to_mem_ctrler
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer in one cycle;
// a miss issues one aligned read to mem_ctrler, waits MEM_LAT cycles for the word,
// fills the line and forwards the word unless the IFU cancelled meanwhile.
module icache #(
    parameter int INDEX_WIDTH = 6,
    parameter int MEM_LAT     = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;
    localparam int CNT_WIDTH = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, MISS_REQ = 2'd1, MISS_WAIT = 2'd2} state_t;

    state_t                 state_reg, state_next;
    logic [LINES-1:0]       line_valid_reg;
    logic [TAG_WIDTH-1:0]   tag_mem [LINES];
    logic [31:0]            data_mem [LINES];

    logic                   discard_reg, discard_next;
    logic                   ready_reg, ready_next;
    logic [31:0]            inst_reg, inst_next;
    logic [31:0]            mem_addr_reg, mem_addr_next;
    logic                   mem_valid_reg, mem_valid_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   fill_we;

    logic [INDEX_WIDTH-1:0] req_index, miss_index;
    logic [TAG_WIDTH-1:0]   req_tag, miss_tag;
    logic                   request, hit, cnt_zero;
    logic                   unused_addr_bits;

    assign req_index  = bus.addr_from_ifu[INDEX_WIDTH+1:2];
    assign req_tag    = bus.addr_from_ifu[31:INDEX_WIDTH+2];
    // The miss address register doubles as the latched tag/index of the line being filled.
    assign miss_index = mem_addr_reg[INDEX_WIDTH+1:2];
    assign miss_tag   = mem_addr_reg[31:INDEX_WIDTH+2];
    assign unused_addr_bits = ^bus.addr_from_ifu[1:0];

    // A request is ignored in the pulse cycle so hit throughput is one per two cycles.
    assign request  = bus.valid_from_ifu && !ready_reg && !bus.cancel_from_ifu;
    assign hit      = line_valid_reg[req_index] && (tag_mem[req_index] == req_tag);
    assign cnt_zero = (cnt_reg == '0);

    assign bus.inst_to_ifu         = inst_reg;
    assign bus.ready_to_ifu        = ready_reg;
    assign bus.addr_to_mem_ctrler  = mem_addr_reg;
    assign bus.valid_to_mem_ctrler = mem_valid_reg;

    // State register; rdy=0 freezes the machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else if (rdy)
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (request && !hit)               state_next = MISS_REQ;
            MISS_REQ:  if (bus.ready_from_mem_ctrler)     state_next = MISS_WAIT;
            MISS_WAIT: if (cnt_zero)                      state_next = IDLE;
            default:                                      state_next = IDLE;
        endcase
    end

    // Output / datapath next values for each state.
    always_comb begin
        ready_next     = 1'b0;
        inst_next      = inst_reg;
        mem_addr_next  = mem_addr_reg;
        mem_valid_next = mem_valid_reg;
        discard_next   = discard_reg;
        cnt_next       = cnt_reg;
        fill_we        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        ready_next = 1'b1;
                        inst_next  = data_mem[req_index];
                    end else begin
                        mem_addr_next  = {bus.addr_from_ifu[31:2], 2'b00};
                        mem_valid_next = 1'b1;
                        discard_next   = 1'b0;
                    end
                end
            end
            MISS_REQ: begin
                if (bus.cancel_from_ifu)
                    discard_next = 1'b1;
                if (bus.ready_from_mem_ctrler) begin
                    mem_valid_next = 1'b0;
                    cnt_next       = CNT_WIDTH'(MEM_LAT - 1);
                end
            end
            MISS_WAIT: begin
                if (bus.cancel_from_ifu)
                    discard_next = 1'b1;
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    // The fill always lands in the array; only the IFU pulse is suppressed.
                    fill_we = 1'b1;
                    if (!discard_reg && !bus.cancel_from_ifu) begin
                        inst_next  = bus.data_from_mem_ctrler;
                        ready_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control and output registers, including per-line valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid_reg <= '0;
            discard_reg    <= 1'b0;
            ready_reg      <= 1'b0;
            inst_reg       <= '0;
            mem_addr_reg   <= '0;
            mem_valid_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else if (rdy) begin
            if (fill_we)
                line_valid_reg[miss_index] <= 1'b1;
            discard_reg   <= discard_next;
            ready_reg     <= ready_next;
            inst_reg      <= inst_next;
            mem_addr_reg  <= mem_addr_next;
            mem_valid_reg <= mem_valid_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Tag and data arrays are not reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_mem[miss_index]  <= miss_tag;
            data_mem[miss_index] <= bus.data_from_mem_ctrler;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// against an array model of the cache contents.
module tb_icache;
    localparam int IW  = 6;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Reference model: what each line should hold, indexed by addr[IW+1:2].
    bit          mv [1<<IW];
    logic [31:0] mt [1<<IW];
    logic [31:0] md [1<<IW];

    icache_if bus();

    icache #(.INDEX_WIDTH(IW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
    );

    always #5 clk = ~clk;

    // One complete IFU fetch; hit/miss is decided by the model. On a miss the bench
    // plays mem_ctrler: ready after rdelay cycles, data valid only in the one cycle
    // MEM_LAT (+ frozen cycles) after the ready pulse. cancel_k>0 cancels at that step.
    task automatic fetch(input logic [31:0] a, input logic [31:0] fill, input int rdelay,
                         input int cancel_k, input int freeze_len, input string name);
        int idx;
        logic [31:0] tg;
        bit hit;
        logic [65:0] snap;
        logic [65:0] now;
        idx = int'(a[IW+1:2]);
        tg  = a >> (IW + 2);
        hit = mv[idx] && (mt[idx] == tg);
        snap = '0;
        @(negedge clk);
        bus.valid_from_ifu = 1'b1;
        bus.addr_from_ifu  = a;
        @(negedge clk);
        if (hit) begin
            checks++; if (bus.ready_to_ifu !== 1'b1) begin errors++; $display("FAIL %s hit_ready got=%b exp=1", name, bus.ready_to_ifu); end
            checks++; if (bus.inst_to_ifu !== md[idx]) begin errors++; $display("FAIL %s hit_inst got=%h exp=%h", name, bus.inst_to_ifu, md[idx]); end
            checks++; if (bus.valid_to_mem_ctrler !== 1'b0) begin errors++; $display("FAIL %s hit_no_mem got=%b exp=0", name, bus.valid_to_mem_ctrler); end
            bus.valid_from_ifu = 1'b0;
            $display("%s: addr=%h hit inst=%h", name, a, bus.inst_to_ifu);
        end else begin
            checks++; if (bus.valid_to_mem_ctrler !== 1'b1) begin errors++; $display("FAIL %s miss_valid got=%b exp=1", name, bus.valid_to_mem_ctrler); end
            checks++; if (bus.addr_to_mem_ctrler !== {a[31:2], 2'b00}) begin errors++; $display("FAIL %s miss_addr got=%h exp=%h", name, bus.addr_to_mem_ctrler, {a[31:2], 2'b00}); end
            checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL %s miss_no_pulse got=%b exp=0", name, bus.ready_to_ifu); end
            for (int i = 0; i < rdelay; i++) begin
                @(negedge clk);
                checks++; if (bus.valid_to_mem_ctrler !== 1'b1) begin errors++; $display("FAIL %s req_held got=%b exp=1", name, bus.valid_to_mem_ctrler); end
            end
            bus.ready_from_mem_ctrler = 1'b1;
            @(negedge clk);
            bus.ready_from_mem_ctrler = 1'b0;
            for (int k = 1; k <= LAT + freeze_len; k++) begin
                now = {bus.ready_to_ifu, bus.valid_to_mem_ctrler, bus.inst_to_ifu, bus.addr_to_mem_ctrler};
                checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL %s early_pulse step=%0d got=%b exp=0", name, k, bus.ready_to_ifu); end
                if (k == 1) begin
                    checks++; if (bus.valid_to_mem_ctrler !== 1'b0) begin errors++; $display("FAIL %s req_drop got=%b exp=0", name, bus.valid_to_mem_ctrler); end
                    snap = now;
                end
                if (k >= 2 && k <= freeze_len + 1) begin
                    checks++; if (now !== snap) begin errors++; $display("FAIL %s frozen_outputs step=%0d got=%h exp=%h", name, k, now, snap); end
                end
                rdy = (k > freeze_len);
                bus.data_from_mem_ctrler = (k == LAT + freeze_len) ? fill : ~fill;
                if (k == cancel_k) begin
                    bus.cancel_from_ifu = 1'b1;
                    bus.valid_from_ifu  = 1'b0;
                end else begin
                    bus.cancel_from_ifu = 1'b0;
                end
                @(negedge clk);
            end
            bus.cancel_from_ifu      = 1'b0;
            bus.data_from_mem_ctrler = ~fill;
            rdy = 1'b1;
            if (cancel_k < 0) begin
                checks++; if (bus.ready_to_ifu !== 1'b1) begin errors++; $display("FAIL %s fill_pulse got=%b exp=1", name, bus.ready_to_ifu); end
                checks++; if (bus.inst_to_ifu !== fill) begin errors++; $display("FAIL %s fill_inst got=%h exp=%h", name, bus.inst_to_ifu, fill); end
                bus.valid_from_ifu = 1'b0;
            end else begin
                checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL %s cancel_no_pulse got=%b exp=0", name, bus.ready_to_ifu); end
                @(negedge clk);
                checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL %s cancel_no_late_pulse got=%b exp=0", name, bus.ready_to_ifu); end
            end
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = fill;
            $display("%s: addr=%h miss fill=%h cancel=%0d freeze=%0d", name, a, fill, cancel_k, freeze_len);
        end
    endtask

    task automatic test_reset();
        bus.addr_from_ifu = '0; bus.valid_from_ifu = 1'b0; bus.cancel_from_ifu = 1'b0;
        bus.data_from_mem_ctrler = '0; bus.ready_from_mem_ctrler = 1'b0;
        for (int i = 0; i < (1<<IW); i++) mv[i] = 1'b0;
        rst = 1'b0;
        #22;
        checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready_to_ifu); end
        checks++; if (bus.valid_to_mem_ctrler !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", bus.valid_to_mem_ctrler); end
        checks++; if (bus.inst_to_ifu !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", bus.inst_to_ifu); end
        checks++; if (bus.addr_to_mem_ctrler !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.addr_to_mem_ctrler); end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        fetch(32'h0000_1000, 32'h0000_0013, 0, -1, 0, "basic_miss");
        fetch(32'h0000_1000, 32'h0, 0, -1, 0, "basic_hit");
    endtask

    task automatic test_evict();
        fetch(32'h0000_1100, 32'hDEAD_BEEF, 1, -1, 0, "evict_miss");
        fetch(32'h0000_1100, 32'h0, 0, -1, 0, "evict_hit");
        fetch(32'h0000_1000, 32'h0000_0013, 2, -1, 0, "evict_refetch");
    endtask

    task automatic test_cancel();
        fetch(32'h0000_2004, 32'h1234_5678, 0, 1, 0, "cancel_wait");
        fetch(32'h0000_2004, 32'h0, 0, -1, 0, "cancel_then_hit");
        fetch(32'h0000_2108, 32'hCAFE_F00D, 0, LAT, 0, "cancel_fill_cycle");
        fetch(32'h0000_2108, 32'h0, 0, -1, 0, "cancel_fill_hit");
    endtask

    task automatic test_cancel_idle();
        @(negedge clk);
        bus.valid_from_ifu = 1'b1; bus.cancel_from_ifu = 1'b1; bus.addr_from_ifu = 32'h0000_3000;
        @(negedge clk);
        checks++; if (bus.valid_to_mem_ctrler !== 1'b0) begin errors++; $display("FAIL cancel_idle_no_mem got=%b exp=0", bus.valid_to_mem_ctrler); end
        checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL cancel_idle_no_pulse got=%b exp=0", bus.ready_to_ifu); end
        bus.valid_from_ifu = 1'b0; bus.cancel_from_ifu = 1'b0;
        $display("cancel_idle: addr=00003000 dropped");
    endtask

    task automatic test_freeze();
        fetch(32'h0000_4010, 32'hA5A5_0F0F, 0, -1, 5, "freeze");
    endtask

    task automatic test_back_to_back();
        // Held valid on a hit: pulse, ignored cycle, pulse.
        @(negedge clk);
        bus.valid_from_ifu = 1'b1; bus.addr_from_ifu = 32'h0000_1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.ready_to_ifu !== ((i == 1) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL b2b_pulse cycle=%0d got=%b exp=%b", i, bus.ready_to_ifu, (i != 1)); end
        end
        bus.valid_from_ifu = 1'b0;
        $display("back_to_back: addr=00001000 pulses checked");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.valid_from_ifu = 1'b1; bus.addr_from_ifu = 32'h0000_5000;
        @(negedge clk);
        checks++; if (bus.valid_to_mem_ctrler !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", bus.valid_to_mem_ctrler); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.valid_to_mem_ctrler !== 1'b0) begin errors++; $display("FAIL areset_drop got=%b exp=0", bus.valid_to_mem_ctrler); end
        checks++; if (bus.addr_to_mem_ctrler !== 32'h0) begin errors++; $display("FAIL areset_addr got=%h exp=0", bus.addr_to_mem_ctrler); end
        bus.valid_from_ifu = 1'b0;
        bus.data_from_mem_ctrler = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < (1<<IW); i++) mv[i] = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            checks++; if (bus.ready_to_ifu !== 1'b0) begin errors++; $display("FAIL areset_late_data got=%b exp=0", bus.ready_to_ifu); end
        end
        $display("async_reset: mid-miss reset checked");
        fetch(32'h0000_1000, 32'h0000_0013, 0, -1, 0, "areset_refetch");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int ck;
        for (int n = 0; n < 40; n++) begin
            a  = 32'h0000_8000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            ck = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT)) : -1;
            fetch(a, $urandom, int'($urandom_range(0, 2)), ck, 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_evict();
        test_cancel();
        test_cancel_idle();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
